// File: rtl/button_pio_scheduler_if.sv
// ---------------------------------------------------------------------------
// button_pio_scheduler_if
//
// Purpose:
//   Bundles the signals of button_pio_scheduler other than clk and reset:
//   the shared Avalon-MM master bus to the button PIO cores, the PIO irq
//   lines, the button event stream and the enable/busy control pair.
//
// Parameters:
//   NUM_PIO  number of button PIO cores on the bus
//   ID_W     width of evt_id
//
// Signals:
//   enable         scanning allowed
//   pio_cs         one-hot chipselect, bit i selects PIO i
//   pio_address    register address shared by all PIOs
//   pio_write_n    active-low write strobe, shared
//   pio_writedata  write data, shared
//   pio_readdata   concatenated readdata, PIO i at [32*i+31:32*i]
//   pio_irq        PIO irq lines
//   evt_valid      button event available
//   evt_id         index of the PIO that captured the press
//   evt_ready      consumer accepts the event
//   busy           scheduler is not idle
//
// Modports:
//   master  the scheduler side (drives the PIO bus and the event stream)
//   slave   the environment side (PIO cores, event consumer, control)
// ---------------------------------------------------------------------------
interface button_pio_scheduler_if #(
    parameter int NUM_PIO = 3,
    parameter int ID_W    = 3
) ();
    logic                   enable;
    logic [NUM_PIO-1:0]     pio_cs;
    logic [1:0]             pio_address;
    logic                   pio_write_n;
    logic [31:0]            pio_writedata;
    logic [32*NUM_PIO-1:0]  pio_readdata;
    logic [NUM_PIO-1:0]     pio_irq;
    logic                   evt_valid;
    logic [ID_W-1:0]        evt_id;
    logic                   evt_ready;
    logic                   busy;

    modport master (
        input  enable,
        output pio_cs,
        output pio_address,
        output pio_write_n,
        output pio_writedata,
        input  pio_readdata,
        input  pio_irq,
        output evt_valid,
        output evt_id,
        input  evt_ready,
        output busy
    );

    modport slave (
        output enable,
        input  pio_cs,
        input  pio_address,
        input  pio_write_n,
        input  pio_writedata,
        output pio_readdata,
        output pio_irq,
        input  evt_valid,
        input  evt_id,
        output evt_ready,
        input  busy
    );
endinterface

// File: rtl/button_pio_scheduler.sv
// ---------------------------------------------------------------------------
// button_pio_scheduler
//
// Purpose:
//   Avalon-MM master that owns a bank of single-bit button PIO cores. On
//   every poll tick it reads each PIO's edge-capture register (address 3),
//   clears a captured edge by writing 0 back, and emits one event carrying
//   the PIO index on a valid/ready stream.
//
// Parameters:
//   NUM_PIO      number of PIO cores serviced (1..8)
//   POLL_CYCLES  clock cycles between scan starts (>= 2*NUM_PIO*4)
//   ID_W         width of evt_id, 2**ID_W >= NUM_PIO
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    button_pio_scheduler_if.master: enable, PIO bus (pio_cs,
//          pio_address, pio_write_n, pio_writedata, pio_readdata),
//          pio_irq, event stream (evt_valid, evt_id, evt_ready), busy
//
// Optional feature (macro BUTTON_PIO_SCHED_IRQ_WAKE_EN):
//   When defined, an INIT sequence after reset writes irq_mask=1 (address 2)
//   to every PIO, and a high pio_irq bit in IDLE also starts a scan, rate
//   limited to one scan start per 2*NUM_PIO cycles. When undefined, pio_irq
//   is ignored and scans are started by the poll timer only.
//
// All PIO bus outputs, the event stream and busy are registered: they are
// loaded on the edge that enters the state they belong to.
// ---------------------------------------------------------------------------
module button_pio_scheduler #(
    parameter int NUM_PIO     = 3,
    parameter int POLL_CYCLES = 500000,
    parameter int ID_W        = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    button_pio_scheduler_if.master bus
);
    localparam int                TMR_W     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(POLL_CYCLES - 1);
    localparam logic [ID_W-1:0]   IDX_LAST  = ID_W'(NUM_PIO - 1);
    localparam logic [1:0]        ADDR_EDGE = 2'd3;   // edge-capture register
    localparam logic [1:0]        ADDR_MASK = 2'd2;   // irq mask register

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        CLR,
        EMIT,
`ifdef BUTTON_PIO_SCHED_IRQ_WAKE_EN
        NEXT,
        INIT
`else
        NEXT
`endif
    } state_t;

    state_t                 state_q;
    logic [ID_W-1:0]        idx_q;
    logic [TMR_W-1:0]       tmr_q;
    logic [TMR_W-1:0]       tmr_d;
    logic                   tick;
    logic                   tick_pend_q;
    logic                   tick_pend_d;
    logic                   scan_start;

    logic [NUM_PIO-1:0]     cs_q;
    logic [1:0]             addr_q;
    logic                   wn_q;
    logic [31:0]            wd_q;
    logic                   evt_valid_q;
    logic [ID_W-1:0]        evt_id_q;
    logic                   busy_q;

    // One-hot decodes of the current and the following PIO index, and the
    // edge-capture bit (bit 0) of every PIO readdata slice.
    logic [NUM_PIO-1:0]     sel_cur;
    logic [NUM_PIO-1:0]     sel_inc;
    logic [NUM_PIO-1:0]     edge_bit;
    logic                   captured;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIO; gi++) begin : g_pio
            assign sel_cur[gi]  = (idx_q == ID_W'(gi));
            assign sel_inc[gi]  = ((idx_q + ID_W'(1)) == ID_W'(gi));
            assign edge_bit[gi] = bus.pio_readdata[32*gi];
        end
    endgenerate

    // Readdata has one cycle of latency, so in RD_WAIT the slice of PIO idx
    // already holds the edge-capture value addressed in RD_ADDR.
    assign captured = |(edge_bit & sel_cur);

    // Only bit 0 of each readdata slice carries information; pio_irq is
    // only consumed by the irq-wake build.
    logic unused_inputs;
    assign unused_inputs = ^{bus.pio_irq, bus.pio_readdata};

    // ------------------------------------------------------------------
    // Poll timer: free-running regardless of enable. The wrap cycle is the
    // tick; ticks that arrive while a scan is pending coalesce into one.
    // ------------------------------------------------------------------
    assign tick = (tmr_q == TMR_LAST);

    always_comb begin
        tmr_d       = tick ? '0 : tmr_q + TMR_W'(1);
        // A tick in the same cycle as a scan start is kept: that tick
        // belongs to the following scan period.
        tick_pend_d = tick | (tick_pend_q & ~scan_start);
    end

`ifdef BUTTON_PIO_SCHED_IRQ_WAKE_EN
    localparam int               HO_W    = $clog2(2*NUM_PIO + 1);
    localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(2*NUM_PIO);

    logic [HO_W-1:0] holdoff_q;
    logic            init_done_q;
    logic            irq_wake;

    // Holdoff stops a held button (irq that re-asserts) from restarting
    // scans back to back.
    assign irq_wake   = (|bus.pio_irq) && (holdoff_q == '0);
    assign scan_start = (state_q == IDLE) && init_done_q && bus.enable &&
                        (tick_pend_q || irq_wake);
`else
    assign scan_start = (state_q == IDLE) && bus.enable && tick_pend_q;
`endif

    // ------------------------------------------------------------------
    // Scan FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tmr_q       <= '0;
            tick_pend_q <= 1'b0;
            cs_q        <= '0;
            addr_q      <= '0;
            wn_q        <= 1'b1;
            wd_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            busy_q      <= 1'b0;
`ifdef BUTTON_PIO_SCHED_IRQ_WAKE_EN
            holdoff_q   <= '0;
            init_done_q <= 1'b0;
`endif
        end else begin
            tmr_q       <= tmr_d;
            tick_pend_q <= tick_pend_d;

            // Every PIO access lasts exactly one cycle: the bus returns to
            // idle unless the transition below starts a new access.
            cs_q   <= '0;
            addr_q <= '0;
            wn_q   <= 1'b1;
            wd_q   <= '0;

`ifdef BUTTON_PIO_SCHED_IRQ_WAKE_EN
            if (scan_start) begin
                holdoff_q <= HO_LOAD;
            end else if (holdoff_q != '0) begin
                holdoff_q <= holdoff_q - HO_W'(1);
            end
`endif

            case (state_q)
                IDLE: begin
`ifdef BUTTON_PIO_SCHED_IRQ_WAKE_EN
                    if (!init_done_q) begin
                        // First pass after reset: unmask irq on PIO 0.
                        state_q <= INIT;
                        idx_q   <= '0;
                        cs_q    <= NUM_PIO'(1);
                        addr_q  <= ADDR_MASK;
                        wn_q    <= 1'b0;
                        wd_q    <= 32'd1;
                        busy_q  <= 1'b1;
                    end else
`endif
                    if (scan_start) begin
                        state_q <= RD_ADDR;
                        idx_q   <= '0;
                        cs_q    <= NUM_PIO'(1);
                        addr_q  <= ADDR_EDGE;
                        busy_q  <= 1'b1;
                    end
                end

                RD_ADDR: begin
                    state_q <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (captured) begin
                        // Writing 0 to edge-capture clears the press.
                        state_q <= CLR;
                        cs_q    <= sel_cur;
                        addr_q  <= ADDR_EDGE;
                        wn_q    <= 1'b0;
                        wd_q    <= '0;
                    end else begin
                        state_q <= NEXT;
                    end
                end

                CLR: begin
                    state_q     <= EMIT;
                    evt_valid_q <= 1'b1;
                    evt_id_q    <= idx_q;
                end

                EMIT: begin
                    // Hold the event until accepted; no timeout.
                    if (bus.evt_ready) begin
                        evt_valid_q <= 1'b0;
                        state_q     <= NEXT;
                    end
                end

                NEXT: begin
                    // Dropping enable ends the scan after the PIO just
                    // serviced; a pending tick stays pending.
                    if ((idx_q == IDX_LAST) || !bus.enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= RD_ADDR;
                        idx_q   <= idx_q + ID_W'(1);
                        cs_q    <= sel_inc;
                        addr_q  <= ADDR_EDGE;
                    end
                end

`ifdef BUTTON_PIO_SCHED_IRQ_WAKE_EN
                INIT: begin
                    if (idx_q == IDX_LAST) begin
                        state_q     <= IDLE;
                        idx_q       <= '0;
                        busy_q      <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        idx_q  <= idx_q + ID_W'(1);
                        cs_q   <= sel_inc;
                        addr_q <= ADDR_MASK;
                        wn_q   <= 1'b0;
                        wd_q   <= 32'd1;
                    end
                end
`endif

                default: begin
                    state_q     <= IDLE;
                    evt_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pio_cs        = cs_q;
    assign bus.pio_address   = addr_q;
    assign bus.pio_write_n   = wn_q;
    assign bus.pio_writedata = wd_q;
    assign bus.evt_valid     = evt_valid_q;
    assign bus.evt_id        = evt_id_q;
    assign bus.busy          = busy_q;

endmodule
